io_bridge: RTL and testbench

//  Multi-channel memory/MMIO bridge between the CPU datapath and NUM_CH peripherals; replaces the fixed LED/switch mux.
//  - Decodes the ALU address into per-channel chip selects.
//  - Handshakes each IO access with a per-device ready.
//  - Stalls the core while an access is in flight.
//  - Returns registered, zero-extended read data to the register file.
//  - The memory path stays combinational pass-through.

---
 rtl/io_bridge_pkg.sv | 19 +
 rtl/io_addr_decode.sv | 25 ++
 rtl/io_bridge.sv | 169 ++++++++++++++++
 tb/tb_io_bridge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the IO bridge
package io_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Channel index field is always 3 bits wide, independent of NUM_CH.
    localparam int CH_IDX_W = 3;

    // Width of the optional ACCESS timeout counter.
    localparam int TO_CNT_W = 8;

    // Load data returned for an IO load that does not hit a channel.
    localparam logic [31:0] IO_MISS_RDATA = 32'h0000_0000;

endpackage

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - combinational IO window decode into hit and channel index
module io_addr_decode
    import io_bridge_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] IO_BASE      = 32'hFFFF_FC00,
    parameter int                CH_SPAN_LOG2 = 4,
    parameter int                NUM_CH       = 4
) (
    input  logic [ADDR_W-1:0]   addr_in,
    output logic                hit,
    output logic [CH_IDX_W-1:0] ch
);

    localparam int TAG_LSB = CH_SPAN_LOG2 + CH_IDX_W;
    localparam logic [ADDR_W-1:0] BASE = IO_BASE;

    // Byte offset inside a channel window does not take part in the decode.
    logic unused_offset;
    assign unused_offset = ^addr_in[CH_SPAN_LOG2-1:0];

    assign ch  = addr_in[TAG_LSB-1:CH_SPAN_LOG2];
    assign hit = (addr_in[ADDR_W-1:TAG_LSB] == BASE[ADDR_W-1:TAG_LSB]) && (32'(ch) < NUM_CH);

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - CPU memory/MMIO bridge; optional ACCESS timeout via IO_BRIDGE_TIMEOUT_EN
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                NUM_CH       = 4,
    parameter int                DEV_W        = 16,
    parameter logic [ADDR_W-1:0] IO_BASE      = 32'hFFFF_FC00,
    parameter int                CH_SPAN_LOG2 = 4,
    parameter int                TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    io_read,
    input  logic                    io_write,
    input  logic [ADDR_W-1:0]       addr_in,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic [DATA_W-1:0]       reg_wdata,
    output logic [ADDR_W-1:0]       addr_out,
    output logic [DATA_W-1:0]       rdata_out,
    output logic [DATA_W-1:0]       wdata_out,
    output logic                    stall,
    output logic [NUM_CH-1:0]       dev_cs,
    output logic                    dev_we,
    output logic                    dev_re,
    output logic [DATA_W-1:0]       dev_wdata,
    input  logic [NUM_CH*DEV_W-1:0] dev_rdata,
    input  logic [NUM_CH-1:0]       dev_ready,
    output logic                    err
);

    state_t                state_q, state_d;
    logic [CH_IDX_W-1:0]   ch_q;
    logic                  rd_q;
    logic [DATA_W-1:0]     rd_hold;
    logic                  hit;
    logic [CH_IDX_W-1:0]   ch;
    logic                  launch, finish, timeout, to_hit;

    // Pad per-channel inputs to the full 3-bit channel space so ch_q indexes cleanly.
    logic [7:0]            ready_pad;
    logic [8*DEV_W-1:0]    rdata_pad;
    logic [DEV_W-1:0]      dev_sel;
    assign ready_pad = 8'(dev_ready);
    assign rdata_pad = (8*DEV_W)'(dev_rdata);
    assign dev_sel   = rdata_pad[32'(ch_q)*DEV_W +: DEV_W];

    io_addr_decode #(
        .ADDR_W       (ADDR_W),
        .IO_BASE      (IO_BASE),
        .CH_SPAN_LOG2 (CH_SPAN_LOG2),
        .NUM_CH       (NUM_CH)
    ) u_decode (
        .addr_in (addr_in),
        .hit     (hit),
        .ch      (ch)
    );

    // Next-state and stall: stall covers the request cycle and every ACCESS cycle.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        launch  = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if ((io_read || io_write) && hit) begin
                    stall   = 1'b1;
                    launch  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (ready_pad[ch_q]) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (to_hit) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access registers: latch the request at launch, drop qualifiers when the access ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            rd_q      <= 1'b0;
            dev_cs    <= '0;
            dev_we    <= 1'b0;
            dev_re    <= 1'b0;
            dev_wdata <= '0;
            rd_hold   <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                ch_q      <= ch;
                rd_q      <= !io_write;
                dev_cs    <= NUM_CH'(1) << ch;
                dev_we    <= io_write;
                dev_re    <= !io_write;
                dev_wdata <= reg_wdata;
            end else if (finish || timeout) begin
                dev_cs <= '0;
                dev_we <= 1'b0;
                dev_re <= 1'b0;
            end
            if (finish && rd_q) begin
                rd_hold <= DATA_W'(dev_sel);
            end else if (timeout) begin
                rd_hold <= '1;
            end
        end
    end

`ifdef IO_BRIDGE_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;
    logic                err_q;

    // ACCESS cycle counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (launch) begin
                to_cnt <= '0;
            end else if (state_q == ACCESS) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // Fires in the TIMEOUT-th ACCESS cycle (counter counts completed cycles).
    assign to_hit = (to_cnt == TO_CNT_W'(TIMEOUT - 1));
    assign err    = err_q;
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // Load data: completed IO read first, any IO load otherwise reads zero, then memory.
    always_comb begin
        rdata_out = mem_rdata;
        if (state_q == DONE && rd_q) begin
            rdata_out = rd_hold;
        end else if (io_read) begin
            rdata_out = DATA_W'(IO_MISS_RDATA);
        end else if (mem_read) begin
            rdata_out = mem_rdata;
        end
    end

    assign addr_out  = addr_in;
    assign wdata_out = (mem_write || io_write) ? reg_wdata : '0;

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - randomized self-checking bench for io_bridge against a transaction model
module tb_io_bridge;

    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
    localparam int          NUM_CH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, io_read = 1'b0, io_write = 1'b0;
    logic [31:0] addr_in = '0, mem_rdata = '0, reg_wdata = '0;
    logic [31:0] addr_out, rdata_out, wdata_out, dev_wdata;
    logic        stall, dev_we, dev_re, err;
    logic [3:0]  dev_cs;
    logic [63:0] dev_rdata = '0;
    logic [3:0]  dev_ready = '0;

    int n_checks = 0;
    int n_errors = 0;

    io_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .io_read   (io_read),
        .io_write  (io_write),
        .addr_in   (addr_in),
        .mem_rdata (mem_rdata),
        .reg_wdata (reg_wdata),
        .addr_out  (addr_out),
        .rdata_out (rdata_out),
        .wdata_out (wdata_out),
        .stall     (stall),
        .dev_cs    (dev_cs),
        .dev_we    (dev_we),
        .dev_re    (dev_re),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ready (dev_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One IO access as the CPU sees it. op: 0 read, 1 write, 2 both strobes.
    // k is the ACCESS cycle on which the selected channel raises ready.
    task automatic io_txn(input logic [31:0] addr, input int op, input int k, input logic [31:0] wd);
        int          ch;
        logic        exp_hit;
        logic [31:0] exp_done;
        logic [3:0]  sel;
        ch      = int'((addr >> 4) & 32'd7);
        exp_hit = ((addr >> 7) == (IO_BASE >> 7)) && (ch < NUM_CH);
        sel     = 4'(1 << ch);
        @(posedge clk); #2;
        io_read   = (op != 1);
        io_write  = (op != 0);
        addr_in   = addr;
        reg_wdata = wd;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dev_ready = '0;
        #3;
        chk("req_stall", stall, exp_hit);
        chk("req_cs", dev_cs, 0);
        chk("req_rdata", rdata_out, (op != 1) ? 32'h0 : mem_rdata);
        chk("req_wdata_out", wdata_out, (op != 0) ? wd : 32'h0);
        chk("addr_out", addr_out, addr);
        if (!exp_hit) begin
            @(posedge clk); #2;
            io_read  = 1'b0;
            io_write = 1'b0;
            #3;
            chk("miss_cs", dev_cs, 0);
            chk("miss_we_re", {dev_we, dev_re}, 0);
            chk("miss_stall", stall, 0);
            return;
        end
        for (int j = 1; j <= k; j++) begin
            @(posedge clk); #2;
            dev_ready = (j == k) ? sel : (4'($urandom) & ~sel);
            #3;
            chk("acc_stall", stall, 1);
            chk("acc_cs", dev_cs, sel);
            chk("acc_we", dev_we, op != 0);
            chk("acc_re", dev_re, op == 0);
            if (op != 0) chk("acc_dev_wdata", dev_wdata, wd);
        end
        if (op == 0)      exp_done = {16'h0, dev_rdata[ch*16 +: 16]};
        else if (op == 2) exp_done = 32'h0;
        else              exp_done = mem_rdata;
        @(posedge clk); #2;
        dev_ready = '0;
        #3;
        chk("done_stall", stall, 0);
        chk("done_cs", dev_cs, 0);
        chk("done_we_re", {dev_we, dev_re}, 0);
        chk("done_rdata", rdata_out, exp_done);
        @(posedge clk); #2;
        io_read  = 1'b0;
        io_write = 1'b0;
        #3;
        chk("idle_stall", stall, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cs", dev_cs, 0);
        chk("rst_we_re", {dev_we, dev_re}, 0);
        chk("rst_dev_wdata", dev_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata", rdata_out, 0);
        rst = 1'b0;

        // Directed: read ch1, write ch3 with late ready, read ch7 miss.
        dev_rdata = 64'h1111_2222_A5A5_3333;
        mem_rdata = 32'h0BAD_0BAD;
        io_txn(32'hFFFF_FC10, 0, 1, 32'h0);
        io_txn(32'hFFFF_FC30, 1, 3, 32'h1234_5678);
        io_txn(32'hFFFF_FC70, 0, 1, 32'h0);

        // Memory path is combinational; IO load takes priority for rdata_out.
        @(posedge clk); #2;
        addr_in = 32'h0000_0100; mem_rdata = 32'hCAFE_F00D; mem_read = 1'b1;
        reg_wdata = 32'h5555_AAAA;
        #3;
        chk("mem_rdata", rdata_out, 32'hCAFE_F00D);
        chk("mem_stall", stall, 0);
        chk("mem_no_wdata", wdata_out, 0);
        #1 mem_read = 1'b0; mem_write = 1'b1;
        #1 chk("mem_wdata", wdata_out, 32'h5555_AAAA);
        #1 io_read = 1'b1; addr_in = 32'hFFFF_FC70; mem_read = 1'b1;
        #1 chk("io_over_mem", rdata_out, 0);
        chk("mixed_wdata", wdata_out, 32'h5555_AAAA);
        #1 io_read = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

        // Reset in the second ACCESS cycle aborts the access asynchronously.
        @(posedge clk); #2;
        io_read = 1'b1; addr_in = 32'hFFFF_FC20; dev_ready = '0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_rst_cs", dev_cs, 4'b0100);
        rst = 1'b1; io_read = 1'b0;
        #1;
        chk("async_cs", dev_cs, 0);
        chk("async_stall", stall, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        io_txn(32'hFFFF_FC20, 0, 2, 32'h0);

        // Randomized accesses across hits, channel misses and foreign windows.
        for (int n = 0; n < 60; n++) begin
            sel       = int'($urandom_range(0, 9));
            dev_rdata = {$urandom, $urandom};
            mem_rdata = $urandom;
            if (sel < 8) a = IO_BASE + 32'(sel % 8) * 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
            else         a = {$urandom_range(0, 32'hFFFF_F7FF)} & 32'hFFFF_FFF0;
            io_txn(a, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), $urandom);
        end

`ifdef IO_BRIDGE_TIMEOUT_EN
        // Silent peripheral: timeout after 15 ACCESS cycles, sticky err.
        @(posedge clk); #2;
        io_read = 1'b1; addr_in = 32'hFFFF_FC00; dev_ready = '0;
        for (int j = 0; j < 15; j++) begin
            @(posedge clk); #3;
            chk("to_stall", stall, 1);
        end
        @(posedge clk); #3;
        chk("to_rdata", rdata_out, 32'hFFFF_FFFF);
        chk("to_err", err, 1);
        @(posedge clk); #2 io_read = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("to_err_sticky", err, 1);
        rst = 1'b1; #1;
        chk("to_err_clr", err, 0);
        @(posedge clk); #2 rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
